// File: rtl/byte_serial_dut_stub_if.sv
// Byte-serial DUT bus: start/plaintext/key toward the responder, done/result/busy back.
interface byte_serial_dut_stub_if;
  logic       start;
  logic [7:0] pt_in;
  logic [7:0] key_in;
  logic       done;
  logic [7:0] ct_out;
  logic       busy;

  modport master (output start, pt_in, key_in, input done, ct_out, busy);
  modport slave  (input start, pt_in, key_in, output done, ct_out, busy);
endinterface

// File: rtl/byte_serial_dut_stub.sv
// Stand-in responder for the masked AES core: capture 16 pt/key bytes, wait LATENCY, stream result.
// Define STUB_SBOX_EN to return SubBytes(pt ^ key) instead of plain pt ^ key.
module byte_serial_dut_stub #(
  parameter int LATENCY = 10,
  parameter int NBYTES  = 16
) (
  input logic clk,
  input logic rst,
  byte_serial_dut_stub_if.slave bus
);
  localparam int         W        = NBYTES * 8;
  localparam logic [3:0] LAST_B   = 4'(NBYTES - 1);
  localparam logic [7:0] LAST_LAT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_EMIT} state_t;

  state_t         state;
  logic [W-1:0]   pt_q, key_q, res_q;
  logic [W-1:0]   pt_nx, key_nx, res_nx;
  logic [3:0]     byte_cnt;
  logic [7:0]     lat_cnt;
  logic           done_q, busy_q;
  logic [7:0]     ct_q;

`ifdef STUB_SBOX_EN
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the field inverse (and maps 0 to 0), followed by the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
`endif

  assign pt_nx  = {pt_q[W-9:0],  bus.pt_in};
  assign key_nx = {key_q[W-9:0], bus.key_in};

  always_comb begin
    res_nx = '0;
    for (int i = 0; i < NBYTES; i++) begin
`ifdef STUB_SBOX_EN
      res_nx[8*i +: 8] = sbox(pt_nx[8*i +: 8] ^ key_nx[8*i +: 8]);
`else
      res_nx[8*i +: 8] = pt_nx[8*i +: 8] ^ key_nx[8*i +: 8];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pt_q     <= '0;
      key_q    <= '0;
      res_q    <= '0;
      byte_cnt <= '0;
      lat_cnt  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ct_q     <= 8'h00;
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        // start from any state restarts capture cleanly
        state    <= S_LOAD;
        byte_cnt <= '0;
        lat_cnt  <= '0;
        ct_q     <= 8'h00;
        busy_q   <= 1'b1;
      end else begin
        case (state)
          S_IDLE: ;
          S_LOAD: begin
            pt_q  <= pt_nx;
            key_q <= key_nx;
            if (byte_cnt == LAST_B) begin
              byte_cnt <= '0;
              lat_cnt  <= '0;
              if (LATENCY == 0) begin
                state  <= S_EMIT;
                done_q <= 1'b1;
                ct_q   <= res_nx[W-1 -: 8];
                res_q  <= res_nx << 8;
              end else begin
                state <= S_WAIT;
                res_q <= res_nx;
              end
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
          S_WAIT: begin
            if (lat_cnt == LAST_LAT) begin
              state  <= S_EMIT;
              done_q <= 1'b1;
              ct_q   <= res_q[W-1 -: 8];
              res_q  <= res_q << 8;
            end else begin
              lat_cnt <= lat_cnt + 8'd1;
            end
          end
          S_EMIT: begin
            if (byte_cnt == LAST_B) begin
              state  <= S_IDLE;
              ct_q   <= 8'h00;
              busy_q <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
              ct_q     <= res_q[W-1 -: 8];
              res_q    <= res_q << 8;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.done   = done_q;
  assign bus.ct_out = ct_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_byte_serial_dut_stub.sv
// Random and directed stimulus on two stubs (LATENCY 10 and 0) checked against a timeline model.
module tb_byte_serial_dut_stub;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] pt, key;
  int         errs = 0, checks = 0;

  int         n = 0;      // posedge count
  bit         vld = 0;    // a block has been started since the last reset
  int         s = 0;      // edge at which that start was sampled
  logic [7:0] cap_pt[16], cap_key[16];

  always #5 clk = ~clk;

  byte_serial_dut_stub_if bus_a();
  byte_serial_dut_stub_if bus_b();
  assign bus_a.start = start;  assign bus_a.pt_in = pt;  assign bus_a.key_in = key;
  assign bus_b.start = start;  assign bus_b.pt_in = pt;  assign bus_b.key_in = key;

  byte_serial_dut_stub #(.LATENCY(10), .NBYTES(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  byte_serial_dut_stub #(.LATENCY(0),  .NBYTES(16)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @edge %0d: got %h want %h", tag, n, got, exp);
    end
  endtask

`ifdef STUB_SBOX_EN
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    int acc = 0, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x << 1;
      if (x > 255) x = x ^ 'h11b;
    end
    return acc[7:0];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv = 8'h00, r;
    for (int y = 1; y < 256; y++) if (gf_mul(a, 8'(y)) == 8'h01) inv = 8'(y);
    r = 8'h63;
    for (int i = 0; i < 5; i++) r = r ^ ((inv << i) | (inv >> (8 - i)));
    return r;
  endfunction
`endif

  function automatic logic [7:0] ref_res(input int i);
`ifdef STUB_SBOX_EN
    return sbox_ref(cap_pt[i] ^ cap_key[i]);
`else
    return cap_pt[i] ^ cap_key[i];
`endif
  endfunction

  // Expected outputs follow from the distance k between now and the last accepted start.
  task automatic check_dut(input string nm, input int lat, input logic d, input logic [7:0] ct,
                           input logic b);
    logic       eb = 1'b0, ed = 1'b0;
    logic [7:0] ec = 8'h00;
    int         k;
    if (vld) begin
      k = n - s;
      if (k >= 0 && k <= 31 + lat) eb = 1'b1;
      if (k == 16 + lat) ed = 1'b1;
      if (k >= 16 + lat && k <= 31 + lat) ec = ref_res(k - 16 - lat);
    end
    chk({nm, ".busy"}, {7'b0, b}, {7'b0, eb});
    chk({nm, ".done"}, {7'b0, d}, {7'b0, ed});
    chk({nm, ".ct"}, ct, ec);
  endtask

  task automatic step(input bit st, input bit r, input logic [7:0] p, input logic [7:0] k);
    @(negedge clk);
    start = st; rst = r; pt = p; key = k;
    @(posedge clk);
    n++;
    if (r) vld = 0;
    else if (st) begin vld = 1; s = n; end
    else if (vld && n - s >= 1 && n - s <= 16) begin
      cap_pt[n-s-1] = p;
      cap_key[n-s-1] = k;
    end
    #1;
    check_dut("L10", 10, bus_a.done, bus_a.ct_out, bus_a.busy);
    check_dut("L0", 0, bus_b.done, bus_b.ct_out, bus_b.busy);
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) step(1'b0, 1'b0, 8'($urandom), 8'($urandom));
  endtask

  task automatic block(input logic [127:0] bp, input logic [127:0] bk);
    step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, bp[127-8*i -: 8], bk[127-8*i -: 8]);
  endtask

  initial begin
    start = 1'b0; rst = 1'b1; pt = 8'h00; key = 8'h00;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'($urandom), 8'($urandom));

    block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
    idle(45);

    // restart during LOAD: start at T, seven junk bytes, second start at T+8
    step(1'b1, 1'b0, 8'h00, 8'h00);
    idle(7);
    block({16{8'hff}}, {16{8'h00}});
    idle(45);

    // reset during the fifth EMIT cycle of the LATENCY=10 stub, then a clean block
    block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    idle(14);
    step(1'b0, 1'b1, 8'($urandom), 8'($urandom));
    block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    idle(45);

    // start coincident with the last EMIT cycle of the LATENCY=10 stub
    block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    idle(25);
    block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    idle(45);

    // reset and start together: reset wins
    step(1'b1, 1'b1, 8'h5a, 8'ha5);
    idle(3);

    // random starts (aborts anywhere) and occasional resets
    for (int i = 0; i < 4000; i++)
      step($urandom_range(59, 0) == 0, $urandom_range(299, 0) == 0, 8'($urandom), 8'($urandom));
    idle(50);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
